a2owb_arb: RTL and testbench

Parametrised N-master Wishbone classic arbiter placed between several `a2owb` core wrappers (or the core plus debug/DMA masters) and the single shared LiteX/cocotb Wishbone slave port. It grants one master at a time by round-robin, forwards one complete classic cycle, and then re-arbitrates. It exposes the codebase's 32-bit `cfg_dat`/`cfg_wr`/`status` config/status convention for a master-enable mask, owner visibility and a transaction counter. Build option: a no-ack bus timeout.

---
 rtl/a2owb_arb_if.sv | 24 ++
 rtl/a2owb_arb.sv | 182 ++++++++++++++++++
 tb/tb_a2owb_arb.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/a2owb_arb_if.sv
// a2owb_arb_if: Wishbone classic bus bundle, N lanes wide.
// The arbiter uses one instance with N = NUM_MASTERS for the master side
// and one with N = 1 for the shared slave side.
//   cyc/stb/we [N]      cycle, strobe, write (bit i = lane i)
//   adr/datw   [32*N]   address, write data (slice [32i+31:32i] = lane i)
//   sel        [4*N]    byte selects
//   ack        [N]      acknowledge back to the initiator
//   datr       [32]     read data, shared by all lanes
// Modports: master = initiator view, slave = target view.
interface a2owb_arb_if #(
  parameter int N = 1
);
  logic [N-1:0]    cyc;
  logic [N-1:0]    stb;
  logic [N-1:0]    we;
  logic [32*N-1:0] adr;
  logic [32*N-1:0] datw;
  logic [4*N-1:0]  sel;
  logic [N-1:0]    ack;
  logic [31:0]     datr;

  modport master (output cyc, stb, we, adr, datw, sel, input ack, datr);
  modport slave  (input cyc, stb, we, adr, datw, sel, output ack, datr);
endinterface

// File: rtl/a2owb_arb.sv
// a2owb_arb: round-robin N-master Wishbone classic arbiter.
// Grants one master at a time, forwards exactly one classic cycle to the
// shared slave, then returns to IDLE to re-arbitrate.
// Build option: define A2OWB_ARB_TIMEOUT_EN to add a no-ack bus timeout.
// Ports:
//   clk_i, rst_i   clock (rising edge), asynchronous active-high reset
//   cfg_dat_i      config word [0:31]; mask in [32-NUM_MASTERS:31], bit 31 =
//                  master 0; bit 0 clears transaction count and timeout flag
//   cfg_wr_i       one-cycle config write strobe
//   status_o       [0] busy, [1] timeout sticky, [2:4] owner, [8:15] mask,
//                  [16:31] transaction count (bit 31 = LSB)
//   m_bus          master-side bus (arbiter acts as target)
//   wb_bus         shared slave bus (arbiter acts as initiator)
// State table:
//   IDLE | no grant; all wb_* and m_ack low; arbitration runs here
//   BUSY | owner's cycle forwarded to the slave until ack/abort/timeout
module a2owb_arb #(
  parameter int                     NUM_MASTERS    = 2,
  parameter logic [NUM_MASTERS-1:0] MASK_RESET     = '1,
  parameter int                     TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [0:31] cfg_dat_i,
  input  logic        cfg_wr_i,
  output logic [0:31] status_o,
  a2owb_arb_if.slave  m_bus,
  a2owb_arb_if.master wb_bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e                 state_q, state_d;
  logic [2:0]             owner_q, owner_d;
  logic [2:0]             last_q, last_d;
  logic [NUM_MASTERS-1:0] mask_q, cfg_mask, req, m_ack;
  logic [15:0]            count_q;
  logic                   sticky;
  logic                   timeout_hit;
  logic                   busy, wb_ack, cnt_clr, ack_done;
  logic [2:0]             grant_idx;
  logic                   grant_found;
  logic                   sel_cyc, sel_stb, sel_we;
  logic [31:0]            sel_adr, sel_datw;
  logic [3:0]             sel_sel;

  assign busy     = (state_q == BUSY);
  assign wb_ack   = wb_bus.ack[0];
  assign req      = m_bus.cyc & m_bus.stb & mask_q;
  assign cnt_clr  = cfg_wr_i & cfg_dat_i[0];
  assign ack_done = busy & wb_ack;

  always_comb begin
    cfg_mask = '0;
    for (int i = 0; i < NUM_MASTERS; i++) cfg_mask[i] = cfg_dat_i[31-i];
  end

  // Round-robin: first requester starting at last+1, wrapping.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      cand = (int'(last_q) + k) % NUM_MASTERS;
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!grant_found && cand == i && req[i]) begin
          grant_found = 1'b1;
          grant_idx   = 3'(i);
        end
      end
    end
  end

  // Owner's signals, selected by comparison to keep indices in range.
  always_comb begin
    sel_cyc  = 1'b0;
    sel_stb  = 1'b0;
    sel_we   = 1'b0;
    sel_adr  = '0;
    sel_datw = '0;
    sel_sel  = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == 3'(i)) begin
        sel_cyc  = m_bus.cyc[i];
        sel_stb  = m_bus.stb[i];
        sel_we   = m_bus.we[i];
        sel_adr  = m_bus.adr[32*i +: 32];
        sel_datw = m_bus.datw[32*i +: 32];
        sel_sel  = m_bus.sel[4*i +: 4];
      end
    end
  end

`ifdef A2OWB_ARB_TIMEOUT_EN
  logic [15:0] to_cnt_q;
  logic        sticky_q;

  // Held at zero in IDLE, so it starts from zero on every entry to BUSY.
  assign timeout_hit = busy && !wb_ack && (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign sticky      = sticky_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      to_cnt_q <= '0;
      sticky_q <= 1'b0;
    end else begin
      to_cnt_q <= busy ? to_cnt_q + 16'd1 : '0;
      if (cnt_clr)          sticky_q <= 1'b0;
      else if (timeout_hit) sticky_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign sticky      = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          state_d = BUSY;
          owner_d = grant_idx;
        end
      end
      BUSY: begin
        if (wb_ack || timeout_hit) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (!sel_cyc) begin
          state_d = IDLE;  // abort: last stays so the round-robin does not advance
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= 3'(NUM_MASTERS - 1);
      mask_q  <= MASK_RESET;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      if (cfg_wr_i) mask_q <= cfg_mask;
      if (cnt_clr)       count_q <= '0;
      else if (ack_done) count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    m_ack = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      m_ack[i] = busy && (owner_q == 3'(i)) && (wb_ack || timeout_hit);
  end

  assign m_bus.ack     = m_ack;
  assign m_bus.datr    = timeout_hit ? 32'hFFFF_FFFF : wb_bus.datr;
  assign wb_bus.cyc[0] = busy & sel_cyc & ~timeout_hit;
  assign wb_bus.stb[0] = busy & sel_stb & ~timeout_hit;
  assign wb_bus.we[0]  = busy & sel_we;
  assign wb_bus.adr    = busy ? sel_adr  : '0;
  assign wb_bus.datw   = busy ? sel_datw : '0;
  assign wb_bus.sel    = busy ? sel_sel  : '0;

  always_comb begin
    status_o        = '0;
    status_o[0]     = busy;
    status_o[1]     = sticky;
    status_o[2:4]   = owner_q;
    for (int i = 0; i < NUM_MASTERS; i++) status_o[15-i] = mask_q[i];
    status_o[16:31] = count_q;
  end

endmodule

// File: tb/tb_a2owb_arb.sv
// Directed testbench for a2owb_arb with two masters. Inputs change 1 ns
// after the rising edge; outputs are checked before the next edge.
module tb_a2owb_arb;
  localparam int          NM    = 2;
  localparam logic [31:0] ADR_A = 32'h0000_1000;
  localparam logic [31:0] ADR_B = 32'h0000_20B4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] cfg_dat = '0;
  logic        cfg_wr = 1'b0;
  logic [0:31] status;
  int          vec_cnt = 0;
  int          err_cnt = 0;

  a2owb_arb_if #(.N(NM)) m_if ();
  a2owb_arb_if #(.N(1))  wb_if ();

  a2owb_arb #(
    .NUM_MASTERS   (NM),
    .MASK_RESET    (2'b11),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .cfg_dat_i(cfg_dat),
    .cfg_wr_i (cfg_wr),
    .status_o (status),
    .m_bus    (m_if),
    .wb_bus   (wb_if)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_st(input logic b, input logic s, input logic [2:0] o,
                                         input logic [1:0] m, input logic [15:0] c);
    return {b, s, o, 3'b000, 6'b000000, m, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int i, input logic on, input logic [31:0] a, input logic w,
                       input logic [31:0] d);
    m_if.cyc[i]          = on;
    m_if.stb[i]          = on;
    m_if.we[i]           = w;
    m_if.adr[32*i +: 32] = a;
    m_if.datw[32*i +: 32] = d;
    m_if.sel[4*i +: 4]   = on ? 4'hF : 4'h0;
  endtask

  task automatic cfg_write(input logic [31:0] d);
    cfg_dat = d;
    cfg_wr  = 1'b1;
    tick();
    cfg_wr  = 1'b0;
    cfg_dat = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    vec_cnt++;
    if ({wb_if.cyc, wb_if.stb, wb_if.we, wb_if.adr, wb_if.datw, wb_if.sel} !== '0) begin
      err_cnt++;
      $display("FAIL reset_wb: got cyc=%b stb=%b adr=%h want all zero", wb_if.cyc, wb_if.stb, wb_if.adr);
    end
    vec_cnt++;
    if (status !== exp_st(0, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL reset_status: got %h want %h", status, exp_st(0, 0, 0, 2'b11, 0));
    end
    wb_if.datr = 32'hDEAD_BEEF;
    #1;
    vec_cnt++;
    if (m_if.datr !== 32'hDEAD_BEEF || m_if.ack !== 2'b00) begin
      err_cnt++;
      $display("FAIL idle_passthru: got datr=%h ack=%b want datr=deadbeef ack=00", m_if.datr, m_if.ack);
    end
    wb_if.datr = '0;
  endtask

  task automatic test_single_read();
    tick();
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    #1;
    vec_cnt++;
    if (wb_if.cyc !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_latency: got wb_cyc=%b want 0 before grant edge", wb_if.cyc);
    end
    tick();
    vec_cnt++;
    if ({wb_if.cyc, wb_if.stb, wb_if.we, wb_if.adr, wb_if.sel} !== {3'b110, ADR_A, 4'hF}) begin
      err_cnt++;
      $display("FAIL single_grant: got cyc=%b stb=%b we=%b adr=%h sel=%h want cyc=1 stb=1 we=0 adr=%h sel=f",
               wb_if.cyc, wb_if.stb, wb_if.we, wb_if.adr, wb_if.sel, ADR_A);
    end
    vec_cnt++;
    if (status !== exp_st(1, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL single_busy_status: got %h want %h", status, exp_st(1, 0, 0, 2'b11, 0));
    end
    tick();
    vec_cnt++;
    if (m_if.ack !== 2'b00) begin
      err_cnt++;
      $display("FAIL single_noack: got m_ack=%b want 00", m_if.ack);
    end
    tick();
    wb_if.ack  = 1'b1;
    wb_if.datr = 32'h1234_5678;
    #1;
    vec_cnt++;
    if (m_if.ack !== 2'b01 || m_if.datr !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL single_ack: got ack=%b datr=%h want ack=01 datr=12345678", m_if.ack, m_if.datr);
    end
    tick();
    wb_if.ack  = 1'b0;
    wb_if.datr = '0;
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    vec_cnt++;
    if (wb_if.cyc !== 1'b0 || status !== exp_st(0, 0, 0, 2'b11, 1)) begin
      err_cnt++;
      $display("FAIL single_done: got cyc=%b status=%h want cyc=0 status=%h",
               wb_if.cyc, status, exp_st(0, 0, 0, 2'b11, 1));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    logic        ew;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    set_m(1, 1'b1, ADR_B, 1'b1, 32'hCAFE_0001);
    #1;
    for (int g = 0; g < 4; g++) begin
      ea = (g % 2 == 1) ? ADR_B : ADR_A;
      ew = (g % 2 == 1);
      vec_cnt++;
      if (wb_if.cyc !== 1'b0) begin
        err_cnt++;
        $display("FAIL b2b_idle_gap g=%0d: got wb_cyc=%b want 0", g, wb_if.cyc);
      end
      tick();
      vec_cnt++;
      if ({wb_if.cyc, wb_if.we, wb_if.adr} !== {1'b1, ew, ea}) begin
        err_cnt++;
        $display("FAIL b2b_grant g=%0d: got cyc=%b we=%b adr=%h want cyc=1 we=%b adr=%h",
                 g, wb_if.cyc, wb_if.we, wb_if.adr, ew, ea);
      end
      wb_if.ack  = 1'b1;
      wb_if.datr = 32'(g);
      #1;
      vec_cnt++;
      if (m_if.ack !== ((g % 2 == 1) ? 2'b10 : 2'b01)) begin
        err_cnt++;
        $display("FAIL b2b_ack g=%0d: got m_ack=%b want %b", g, m_if.ack, (g % 2 == 1) ? 2'b10 : 2'b01);
      end
      tick();
      wb_if.ack = 1'b0;
    end
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    vec_cnt++;
    if (status !== exp_st(0, 0, 1, 2'b11, 4)) begin
      err_cnt++;
      $display("FAIL b2b_count: got %h want %h", status, exp_st(0, 0, 1, 2'b11, 4));
    end
  endtask

  task automatic test_mask();
    tick();
    cfg_write(32'h0000_0002);
    vec_cnt++;
    if (status !== exp_st(0, 0, 1, 2'b10, 4)) begin
      err_cnt++;
      $display("FAIL mask_status: got %h want %h", status, exp_st(0, 0, 1, 2'b10, 4));
    end
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    set_m(1, 1'b1, ADR_B, 1'b0, 32'h0);
    for (int g = 0; g < 2; g++) begin
      tick();
      vec_cnt++;
      if (wb_if.cyc !== 1'b1 || wb_if.adr !== ADR_B) begin
        err_cnt++;
        $display("FAIL mask_grant g=%0d: got cyc=%b adr=%h want cyc=1 adr=%h", g, wb_if.cyc, wb_if.adr, ADR_B);
      end
      wb_if.ack = 1'b1;
      tick();
      wb_if.ack = 1'b0;
    end
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    cfg_write(32'h0000_0003);
  endtask

  task automatic test_abort();
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    set_m(1, 1'b1, ADR_B, 1'b0, 32'h0);
    tick();
    vec_cnt++;
    if (status !== exp_st(1, 0, 0, 2'b11, 6) || wb_if.adr !== ADR_A) begin
      err_cnt++;
      $display("FAIL abort_grant0: got status=%h adr=%h want status=%h adr=%h",
               status, wb_if.adr, exp_st(1, 0, 0, 2'b11, 6), ADR_A);
    end
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    vec_cnt++;
    if (wb_if.cyc !== 1'b0 || status !== exp_st(0, 0, 0, 2'b11, 6)) begin
      err_cnt++;
      $display("FAIL abort_idle: got cyc=%b status=%h want cyc=0 status=%h",
               wb_if.cyc, status, exp_st(0, 0, 0, 2'b11, 6));
    end
    tick();
    vec_cnt++;
    if (wb_if.adr !== ADR_B || status !== exp_st(1, 0, 1, 2'b11, 6)) begin
      err_cnt++;
      $display("FAIL abort_regrant: got adr=%h status=%h want adr=%h status=%h",
               wb_if.adr, status, ADR_B, exp_st(1, 0, 1, 2'b11, 6));
    end
    wb_if.ack = 1'b1;
    tick();
    wb_if.ack = 1'b0;
    set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    vec_cnt++;
    if (status !== exp_st(0, 0, 1, 2'b11, 7)) begin
      err_cnt++;
      $display("FAIL abort_count: got %h want %h", status, exp_st(0, 0, 1, 2'b11, 7));
    end
  endtask

  task automatic test_clear();
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    tick();
    wb_if.ack = 1'b1;
    cfg_dat   = 32'h8000_0003;
    cfg_wr    = 1'b1;
    tick();
    cfg_wr    = 1'b0;
    cfg_dat   = '0;
    wb_if.ack = 1'b0;
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    #1;
    vec_cnt++;
    if (status !== exp_st(0, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL clear_wins: got %h want %h", status, exp_st(0, 0, 0, 2'b11, 0));
    end
  endtask

`ifdef A2OWB_ARB_TIMEOUT_EN
  task automatic test_timeout();
    wb_if.datr = 32'h1111_1111;
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    tick();
    tick();
    for (int c = 2; c <= 7; c++) begin
      vec_cnt++;
      if (m_if.ack !== 2'b00 || wb_if.cyc !== 1'b1) begin
        err_cnt++;
        $display("FAIL timeout_wait c=%0d: got ack=%b cyc=%b want ack=00 cyc=1", c, m_if.ack, wb_if.cyc);
      end
      tick();
    end
    vec_cnt++;
    if (m_if.ack !== 2'b01 || m_if.datr !== 32'hFFFF_FFFF || wb_if.cyc !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_fire: got ack=%b datr=%h cyc=%b want ack=01 datr=ffffffff cyc=0",
               m_if.ack, m_if.datr, wb_if.cyc);
    end
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
    vec_cnt++;
    if (status !== exp_st(0, 1, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL timeout_sticky: got %h want %h", status, exp_st(0, 1, 0, 2'b11, 0));
    end
    cfg_write(32'h8000_0003);
    vec_cnt++;
    if (status !== exp_st(0, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL timeout_clear: got %h want %h", status, exp_st(0, 0, 0, 2'b11, 0));
    end
    wb_if.datr = '0;
  endtask
`else
  task automatic test_no_timeout();
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    tick();
    for (int c = 0; c < 20; c++) tick();
    vec_cnt++;
    if (status !== exp_st(1, 0, 0, 2'b11, 0) || m_if.ack !== 2'b00 || wb_if.cyc !== 1'b1) begin
      err_cnt++;
      $display("FAIL no_timeout_hold: got status=%h ack=%b cyc=%b want status=%h ack=00 cyc=1",
               status, m_if.ack, wb_if.cyc, exp_st(1, 0, 0, 2'b11, 0));
    end
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    cfg_write(32'h0000_0002);
    set_m(0, 1'b1, ADR_A, 1'b0, 32'h0);
    set_m(1, 1'b1, ADR_B, 1'b0, 32'h0);
    tick();
    vec_cnt++;
    if (wb_if.cyc !== 1'b1 || status !== exp_st(1, 0, 1, 2'b10, 0)) begin
      err_cnt++;
      $display("FAIL rstmid_busy: got cyc=%b status=%h want cyc=1 status=%h",
               wb_if.cyc, status, exp_st(1, 0, 1, 2'b10, 0));
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if (wb_if.cyc !== 1'b0 || m_if.ack !== 2'b00 || status !== exp_st(0, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL rstmid_async: got cyc=%b ack=%b status=%h want cyc=0 ack=00 status=%h",
               wb_if.cyc, m_if.ack, status, exp_st(0, 0, 0, 2'b11, 0));
    end
    tick();
    rst = 1'b0;
    tick();
    vec_cnt++;
    if (wb_if.cyc !== 1'b1 || wb_if.adr !== ADR_A || status !== exp_st(1, 0, 0, 2'b11, 0)) begin
      err_cnt++;
      $display("FAIL rstmid_first: got cyc=%b adr=%h status=%h want cyc=1 adr=%h status=%h",
               wb_if.cyc, wb_if.adr, status, ADR_A, exp_st(1, 0, 0, 2'b11, 0));
    end
    wb_if.ack = 1'b1;
    tick();
    wb_if.ack = 1'b0;
    set_m(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_m(1, 1'b0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  initial begin
    m_if.cyc   = '0;
    m_if.stb   = '0;
    m_if.we    = '0;
    m_if.adr   = '0;
    m_if.datw  = '0;
    m_if.sel   = '0;
    wb_if.ack  = '0;
    wb_if.datr = '0;
    test_reset();
    test_single_read();
    test_back_to_back();
    test_mask();
    test_abort();
    test_clear();
`ifdef A2OWB_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
